self_ex_slink_diag_filt: RTL
============================

SELF_EX_SLINK_DIAG_FILT -- requirements
Module: self_ex_slink_diag_filt

Interface
REQ-001 SHALL have parameter CHN_NUM, default 4, meaning number of SLINK channels diagnosed (1..16).
REQ-002 SHALL have parameter ERR_THRESH, default 4, meaning consecutive errored cycles to declare fault (2..255).
REQ-003 SHALL have parameter OK_THRESH, default 8, meaning consecutive clean cycles to leave recovery (1..255).
REQ-004 SHALL have port clk_12_5m  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_12_5m  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port chn_enable  input  CHN_NUM  per-channel enable (1 = channel in service).
REQ-007 SHALL have port chn_slink_err  input  CHN_NUM  per-channel raw link error, synchronous to clk_12_5m.
REQ-008 SHALL have port err_clr  input  1  single-cycle fault clear request, all channels.
REQ-009 SHALL have port chn_err_sts  output  CHN_NUM  per-channel filtered error status.
REQ-010 SHALL have port slink_err  output  1  global SLINK error summary.
REQ-011 SHALL have port evt_cnt  output  8*CHN_NUM  per-channel fault event counters, channel i at bits [8i+7:8i].

Function
REQ-012 SHALL run one independent 4-state FSM per channel: OK, SUSPECT, FAULT, RECOVER, with 8-bit run counter cnt.
REQ-013 OK: cnt=0; err=1 -> SUSPECT, cnt=1; err=0 -> stay.
REQ-014 SUSPECT: err=1 and cnt==ERR_THRESH-1 -> FAULT, cnt=0; err=1 otherwise -> cnt+1; err=0 -> OK, cnt=0.
REQ-015 FAULT: sticky; leaves only on err_clr=1 with err=0 -> RECOVER, cnt=1; err_clr=1 with err=1 -> stay FAULT.
REQ-016 RECOVER: err=1 -> FAULT, cnt=0; err=0 and cnt==OK_THRESH -> OK, cnt=0; err=0 otherwise -> cnt+1.
REQ-017 chn_err_sts[i] SHALL be registered, =1 exactly while FSM i is in FAULT or RECOVER, updated on the same edge as the state.
REQ-018 Continuous error sampled from edge 1 SHALL set chn_err_sts[i] at edge ERR_THRESH; a shorter burst SHALL leave it 0.
REQ-019 chn_enable[i]=0 SHALL force FSM i to OK, cnt=0, chn_err_sts[i]=0 on the next edge, overriding all other inputs, including mid-FAULT.
REQ-020 slink_err SHALL be registered, one cycle after its sources: OR over i of (chn_enable[i] ? chn_err_sts[i] : ~chn_slink_err[i]) — a disabled channel reporting a live link (err=0) is an error.
REQ-021 Counters SHALL never wrap; cnt compare uses full 8-bit width.

Reset
REQ-022 On rst_12_5m=0, asynchronously: all FSMs OK, all cnt=0, chn_err_sts=0, slink_err=0, evt_cnt=0.
REQ-023 Reset deassertion mid-burst SHALL restart filtering from OK; no pre-reset history retained.

Configuration
REQ-024 Macro SLINK_DIAG_EVT_CNT_EN defined: evt_cnt[i] SHALL increment on each SUSPECT->FAULT and RECOVER->FAULT transition, saturate at 255, clear to 0 on err_clr (clear has priority over a simultaneous increment).
REQ-025 Macro SLINK_DIAG_EVT_CNT_EN undefined: evt_cnt SHALL be constant 0, no counter registers synthesised; all other behaviour identical.

Verification (CHN_NUM=4, ERR_THRESH=4, OK_THRESH=8, macro defined)
REQ-026 Reset, chn_enable=4'hF, chn_slink_err=0 -> chn_err_sts=0, slink_err=0, evt_cnt=0 indefinitely.
REQ-027 ch0 err=1 for 3 cycles then 0 -> chn_err_sts[0] stays 0; err=1 for 4 cycles -> chn_err_sts[0]=1 at 4th edge, slink_err=1 one edge later, evt_cnt[7:0]=1.
REQ-028 ch1 in FAULT, err=0, no err_clr for 100 cycles -> status held 1; pulse err_clr -> status 1 for 8 more edges, then 0; evt_cnt[15:8] cleared to 0.
REQ-029 ch2 in RECOVER, err=1 at cycle 5 -> immediate return to FAULT, evt_cnt[23:16] +1; ch2 in FAULT, err_clr with err=1 -> stays FAULT.
REQ-030 chn_enable=4'hE, chn_slink_err[0]=0 -> slink_err=1; set chn_slink_err[0]=1 -> slink_err=0 next+1 edge; drop chn_enable[3] mid-FAULT -> chn_err_sts[3]=0 next edge.
REQ-031 Force 300 fault events on ch3 without err_clr -> evt_cnt[31:24]=255; assert rst_12_5m=0 mid-SUSPECT -> all outputs 0 immediately.

Source files
------------

// File: rtl/self_ex_slink_diag_filt.sv
// self_ex_slink_diag_filt: per-channel SLINK error debounce FSMs with global error summary.
// Optional per-channel fault event counters enabled by SLINK_DIAG_EVT_CNT_EN.
module self_ex_slink_diag_filt #(
  parameter int CHN_NUM    = 4,
  parameter int ERR_THRESH = 4,
  parameter int OK_THRESH  = 8
) (
  input  logic                   clk_12_5m,
  input  logic                   rst_12_5m,
  input  logic [CHN_NUM-1:0]     chn_enable,
  input  logic [CHN_NUM-1:0]     chn_slink_err,
  input  logic                   err_clr,
  output logic [CHN_NUM-1:0]     chn_err_sts,
  output logic                   slink_err,
  output logic [8*CHN_NUM-1:0]   evt_cnt
);
  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_SUS = 2'd1;
  localparam logic [1:0] ST_FLT = 2'd2;
  localparam logic [1:0] ST_REC = 2'd3;
  localparam logic [7:0] ERR_LAST = 8'(ERR_THRESH - 1);
  localparam logic [7:0] OK_LAST  = 8'(OK_THRESH);
  logic [1:0] st     [CHN_NUM];
  logic [1:0] st_nx  [CHN_NUM];
  logic [7:0] cnt    [CHN_NUM];
  logic [7:0] cnt_nx [CHN_NUM];
  logic [CHN_NUM-1:0] flt_evt, sts_nx;
  always_comb begin
    flt_evt = '0;
    sts_nx  = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      st_nx[i]  = st[i];
      cnt_nx[i] = 8'd0;
      case (st[i])
        ST_OK: begin
          st_nx[i]  = chn_slink_err[i] ? ST_SUS : ST_OK;
          cnt_nx[i] = chn_slink_err[i] ? 8'd1 : 8'd0;
        end
        ST_SUS: begin
          st_nx[i]  = !chn_slink_err[i] ? ST_OK : cnt[i] == ERR_LAST ? ST_FLT : ST_SUS;
          cnt_nx[i] = st_nx[i] == ST_SUS ? cnt[i] + 8'd1 : 8'd0;
        end
        ST_FLT: begin
          st_nx[i]  = err_clr && !chn_slink_err[i] ? ST_REC : ST_FLT;
          cnt_nx[i] = st_nx[i] == ST_REC ? 8'd1 : 8'd0;
        end
        default: begin
          st_nx[i]  = chn_slink_err[i] ? ST_FLT : cnt[i] == OK_LAST ? ST_OK : ST_REC;
          cnt_nx[i] = st_nx[i] == ST_REC ? cnt[i] + 8'd1 : 8'd0;
        end
      endcase
      flt_evt[i] = chn_enable[i] && st_nx[i] == ST_FLT && st[i] != ST_FLT;
      if (!chn_enable[i]) begin
        st_nx[i]  = ST_OK;
        cnt_nx[i] = 8'd0;
      end
      sts_nx[i] = st_nx[i][1];
    end
  end
  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      for (int i = 0; i < CHN_NUM; i++) begin
        st[i]  <= ST_OK;
        cnt[i] <= 8'd0;
      end
      chn_err_sts <= '0;
      slink_err   <= 1'b0;
    end else begin
      for (int i = 0; i < CHN_NUM; i++) begin
        st[i]  <= st_nx[i];
        cnt[i] <= cnt_nx[i];
      end
      chn_err_sts <= sts_nx;
      // a disabled channel should be dark; a live link there is itself an error
      slink_err   <= |((chn_enable & chn_err_sts) | (~chn_enable & ~chn_slink_err));
    end
  end
`ifdef SLINK_DIAG_EVT_CNT_EN
  logic [7:0] evt [CHN_NUM];
  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      for (int i = 0; i < CHN_NUM; i++) evt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < CHN_NUM; i++)
        evt[i] <= err_clr ? 8'd0 : (flt_evt[i] && evt[i] != 8'hff) ? evt[i] + 8'd1 : evt[i];
    end
  end
  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < CHN_NUM; i++) evt_cnt[8*i +: 8] = evt[i];
  end
`else
  assign evt_cnt = '0;
`endif
endmodule
